// File: rtl/dtree_pkg.sv
// Shared types and constants for the sequential decision-tree walker.
// Optional feature macro: DTREE_WALK_STATS_EN (adds walk_steps output).
package dtree_pkg;

    localparam int N_FEAT    = 18;
    localparam int FEAT_W    = 8;
    localparam int N_NODES   = 64;
    localparam int NODE_AW   = 6;
    localparam int FIDX_W    = 5;
    localparam int CLASS_W   = 2;
    localparam int MAX_DEPTH = 16;

    localparam int CNT_W   = $clog2(N_FEAT);
    localparam int DEPTH_W = $clog2(MAX_DEPTH);
    localparam int STEPS_W = $clog2(MAX_DEPTH + 1);

    // Node word width: leaf + fidx + shift[2:0] + thresh + left + right.
    function automatic int node_w(int fidx_w, int feat_w, int node_aw);
        return 1 + fidx_w + 3 + feat_w + 2 * node_aw;
    endfunction

    localparam int NODE_W = node_w(FIDX_W, FEAT_W, NODE_AW);

    typedef enum logic [1:0] {LOAD, WALK, DONE} state_e;

    typedef struct packed {
        logic               leaf;
        logic [FIDX_W-1:0]  fidx;
        logic [2:0]         shift;
        logic [FEAT_W-1:0]  thresh;
        logic [NODE_AW-1:0] left;
        logic [NODE_AW-1:0] right;
    } node_t;

endpackage

// File: rtl/dtree_seq_walker_if.sv
// Feature stream, result stream, config port and status of the tree walker.
// Optional feature macro: DTREE_WALK_STATS_EN (adds walk_steps).
interface dtree_seq_walker_if;
    import dtree_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [FEAT_W-1:0]  in_feat;
    logic               out_valid;
    logic               out_ready;
    logic [CLASS_W-1:0] out_class;
    logic               out_err;
    logic               cfg_we;
    logic [NODE_AW-1:0] cfg_addr;
    logic [NODE_W-1:0]  cfg_wdata;
    logic               busy;
`ifdef DTREE_WALK_STATS_EN
    logic [STEPS_W-1:0] walk_steps;
`endif

    modport master (
        output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_class, out_err, busy
`ifdef DTREE_WALK_STATS_EN
      , input  walk_steps
`endif
    );

    modport slave (
        input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_class, out_err, busy
`ifdef DTREE_WALK_STATS_EN
      , output walk_steps
`endif
    );

endinterface

// File: rtl/dtree_node_mem.sv
// Node table: register array, one synchronous write port, one async read port.
// Contents are intentionally not reset so a loaded tree survives rst_n.
module dtree_node_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int W     = 29
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dtree_seq_walker.sv
// Sequential decision-tree evaluator: features stream in, one shared
// comparator walks the node table one node per cycle, class streams out.
// Optional feature macro: DTREE_WALK_STATS_EN (walk_steps = nodes visited).
module dtree_seq_walker
    import dtree_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    dtree_seq_walker_if.slave bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NODE_AW-1:0] ptr_q, ptr_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [CLASS_W-1:0] class_q, class_d;
    logic               err_q, err_d;
`ifdef DTREE_WALK_STATS_EN
    logic [STEPS_W-1:0] steps_q, steps_d;
`endif

    logic [FEAT_W-1:0]  feat_q [N_FEAT];
    logic               feat_we;
    logic               busy;
    logic               cfg_en;
    logic [NODE_W-1:0]  node_raw;
    node_t              node;
    logic [FEAT_W-1:0]  feat_sel;
    logic               go_left;

    // Idle means LOAD with no beats taken yet; only then is the table writable.
    assign busy   = !(state_q == LOAD && cnt_q == '0);
    assign cfg_en = bus.cfg_we && !busy;

    dtree_node_mem #(
        .DEPTH (N_NODES),
        .AW    (NODE_AW),
        .W     (NODE_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (cfg_en),
        .waddr_i (bus.cfg_addr),
        .wdata_i (bus.cfg_wdata),
        .raddr_i (ptr_q),
        .rdata_o (node_raw)
    );

    assign node     = node_t'(node_raw);
    // Guarded select; an out-of-range index is flagged as an error in WALK.
    assign feat_sel = (node.fidx < FIDX_W'(N_FEAT)) ? feat_q[node.fidx] : '0;
    assign go_left  = (feat_sel >> node.shift) <= node.thresh;

    // Feature register file; holds no control state so it needs no reset.
    always_ff @(posedge clk) begin
        if (feat_we) feat_q[cnt_q] <= bus.in_feat;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            ptr_q   <= '0;
            depth_q <= '0;
            class_q <= '0;
            err_q   <= 1'b0;
`ifdef DTREE_WALK_STATS_EN
            steps_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            class_q <= class_d;
            err_q   <= err_d;
`ifdef DTREE_WALK_STATS_EN
            steps_q <= steps_d;
`endif
        end
    end

    // Next-state: load beats, take one tree step per cycle, hold result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        depth_d = depth_q;
        class_d = class_q;
        err_d   = err_q;
        feat_we = 1'b0;
`ifdef DTREE_WALK_STATS_EN
        steps_d = steps_q;
`endif
        unique case (state_q)
            LOAD: begin
                if (bus.in_valid) begin
                    feat_we = 1'b1;
                    if (cnt_q == CNT_W'(N_FEAT - 1)) begin
                        cnt_d   = '0;
                        ptr_d   = '0;
                        depth_d = '0;
                        state_d = WALK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WALK: begin
                if (node.leaf) begin
                    class_d = node.thresh[CLASS_W-1:0];
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (node.fidx >= FIDX_W'(N_FEAT) ||
                             depth_q == DEPTH_W'(MAX_DEPTH - 1)) begin
                    class_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    ptr_d   = go_left ? node.left : node.right;
                    depth_d = depth_q + DEPTH_W'(1);
                end
`ifdef DTREE_WALK_STATS_EN
                if (state_d == DONE) steps_d = STEPS_W'(depth_q) + STEPS_W'(1);
`endif
            end
            DONE: begin
                if (bus.out_ready) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_class = class_q;
    assign bus.out_err   = err_q;
    assign bus.busy      = busy;
`ifdef DTREE_WALK_STATS_EN
    assign bus.walk_steps = steps_q;
`endif

endmodule
